// File: rtl/sar_converter.sv
// 8-bit successive-approximation register controller.
// Drives trial codes to an external DAC, reads the comparator back and publishes the result.
module sar_converter (
   input  logic       clock,
   input  logic       reset_,
   input  logic       soc,
   input  logic       comp,
   output logic       eoc,
   output logic [7:0] dac,
   output logic [7:0] numero
);

   typedef enum logic [2:0] {
      StIdle,
      StAck,
      StSet,
      StTest,
      StFin
   } state_e;

   state_e     r_state;
   logic       r_eoc;
   logic [7:0] r_dac;
   logic [7:0] r_numero;
   logic [7:0] r_result;
   logic [2:0] r_index;
   logic [7:0] w_bit;

   assign w_bit  = 8'd1 << r_index;
   assign eoc    = r_eoc;
   assign dac    = r_dac;
   assign numero = r_numero;

   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         r_state  <= StIdle;
         r_eoc    <= 1'b1;
         r_dac    <= 8'h00;
         r_numero <= 8'h00;
         r_result <= 8'h00;
         r_index  <= 3'd7;
      end else begin
         case (r_state)
            StIdle: begin
               if (soc) begin
                  r_eoc   <= 1'b0;
                  r_state <= StAck;
               end
            end
            // Wait for the requester to drop soc before starting the bit loop.
            StAck: begin
               if (!soc) begin
                  r_result <= 8'h00;
                  r_index  <= 3'd7;
                  r_state  <= StSet;
               end
            end
            StSet: begin
               r_dac   <= r_result | w_bit;
               r_state <= StTest;
            end
            StTest: begin
               if (comp) begin
                  r_result <= r_result | w_bit;
               end else begin
                  r_result <= r_result & ~w_bit;
               end
               if (r_index == 3'd0) begin
                  r_state <= StFin;
               end else begin
                  r_index <= r_index - 3'd1;
                  r_state <= StSet;
               end
            end
            StFin: begin
               r_numero <= r_result;
               r_eoc    <= 1'b1;
               r_dac    <= 8'h00;
               r_state  <= StIdle;
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sar_converter.sv
// Directed self-checking bench for sar_converter with an ideal comparator model.
module tb_sar_converter;

   logic       clock;
   logic       reset_;
   logic       soc;
   logic       comp;
   logic       eoc;
   logic [7:0] dac;
   logic [7:0] numero;
   logic [7:0] vin;

   int n_tests;
   int n_fail;

   logic [7:0] a5_seq [8];

   sar_converter dut (
      .clock  (clock),
      .reset_ (reset_),
      .soc    (soc),
      .comp   (comp),
      .eoc    (eoc),
      .dac    (dac),
      .numero (numero)
   );

   assign comp = (vin >= dac);

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, observed running expected done");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // One full conversion from IDLE; expected codes come from a bench-side SAR model.
   task automatic conv(input logic [7:0] v, input logic [7:0] prev_num, input int ack_hold,
                       input bit toggle, input bit hold_end);
      logic [7:0] res;
      logic [7:0] trial;
      logic [7:0] bitm;
      vin = v;
      soc = 1'b1;
      tick();
      chk("start_eoc_low", 32'(eoc), 32'd0);
      chk("start_numero_hold", 32'(numero), 32'(prev_num));
      for (int k = 1; k < ack_hold; k++) begin
         tick();
         chk("ack_eoc_low", 32'(eoc), 32'd0);
         chk("ack_dac_zero", 32'(dac), 32'd0);
      end
      soc = 1'b0;
      tick();
      chk("e0_dac_zero", 32'(dac), 32'd0);
      res = 8'h00;
      for (int i = 7; i >= 0; i--) begin
         if (toggle && i == 7) soc = 1'b1;
         if (toggle && i == 6) soc = 1'b1;
         tick();
         bitm  = 8'd1 << i;
         trial = res | bitm;
         chk("set_dac", 32'(dac), 32'(trial));
         chk("busy_eoc", 32'(eoc), 32'd0);
         chk("busy_numero", 32'(numero), 32'(prev_num));
         if (v == 8'hA5) chk("a5_dac_seq", 32'(dac), 32'(a5_seq[7-i]));
         if (toggle && i >= 6) soc = 1'b0;
         tick();
         if (v >= trial) res = trial;
      end
      chk("e16_eoc_low", 32'(eoc), 32'd0);
      if (hold_end) soc = 1'b1;
      tick();
      chk("e17_eoc_high", 32'(eoc), 32'd1);
      chk("e17_numero", 32'(numero), 32'(v));
      chk("e17_numero_model", 32'(numero), 32'(res));
      chk("e17_dac_zero", 32'(dac), 32'd0);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      a5_seq  = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
      reset_  = 1'b1;
      soc     = 1'b0;
      vin     = 8'h00;
      #1 reset_ = 1'b0;
      #2;
      chk("rst_eoc", 32'(eoc), 32'd1);
      chk("rst_dac", 32'(dac), 32'd0);
      chk("rst_numero", 32'(numero), 32'd0);
      tick();
      reset_ = 1'b1;
      tick();
      chk("idle_eoc", 32'(eoc), 32'd1);

      conv(8'hA5, 8'h00, 1, 1'b0, 1'b0);
      tick();
      chk("idle_numero_hold", 32'(numero), 32'hA5);
      conv(8'h00, 8'hA5, 1, 1'b0, 1'b0);
      conv(8'hFF, 8'h00, 1, 1'b0, 1'b0);

      // Abort mid-conversion: reset just after E9.
      vin = 8'h3C;
      soc = 1'b1;
      tick();
      soc = 1'b0;
      tick();
      repeat (9) tick();
      chk("mid_busy", 32'(eoc), 32'd0);
      reset_ = 1'b0;
      #1;
      chk("abort_eoc", 32'(eoc), 32'd1);
      chk("abort_dac", 32'(dac), 32'd0);
      chk("abort_numero", 32'(numero), 32'd0);
      tick();
      chk("abort_hold_numero", 32'(numero), 32'd0);
      reset_ = 1'b1;
      conv(8'h3C, 8'h00, 1, 1'b0, 1'b0);

      conv(8'h5A, 8'h3C, 1, 1'b1, 1'b0);

      // Back-to-back: soc held high across FIN restarts immediately.
      conv(8'h10, 8'h5A, 1, 1'b0, 1'b1);
      conv(8'hF0, 8'h10, 1, 1'b0, 1'b0);

      conv(8'h77, 8'hF0, 5, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
